// File: rtl/dmux_seq_driver.sv
// Serial scan driver for the 1-to-8 demux: takes a word over valid/ready and
// presents one bit per channel on data_out with the matching channel select.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   word_in, word_valid    - 8-bit word in; word_ready is its registered ready
//   abort                  - synchronous frame cancel
//   data_out, sel          - serial bit and 3-bit channel select to the demux
//   busy, frame_done       - scan active; one-cycle pulse after a full frame
module dmux_seq_driver #(
  parameter int unsigned DWELL   = 1,
  parameter bit          DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  input  logic       abort,
  output logic       data_out,
  output logic [2:0] sel,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [2:0] FIRST  = DESCEND ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST   = DESCEND ? 3'd0 : 3'd7;
  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] dwell_q, dwell_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       dout_q, dout_d;
  logic [2:0] sel_q, sel_d;
  logic       scan_d;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // abort in IDLE suppresses the transfer even though ready is high
        if (word_valid && !abort) begin
          word_d  = word_in;
          idx_d   = FIRST;
          dwell_d = RELOAD;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dwell_q != 8'd0) begin
          dwell_d = dwell_q - 8'd1;
        end else if (idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = DESCEND ? idx_q - 3'd1 : idx_q + 3'd1;
          dwell_d = RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next state so every port is a flop.
  always_comb begin
    scan_d  = (state_d == SCAN);
    ready_d = !scan_d;
    busy_d  = scan_d;
    sel_d   = scan_d ? idx_d : 3'd0;
    dout_d  = scan_d & word_d[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= 8'd0;
      idx_q   <= 3'd0;
      dwell_q <= 8'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
    end
  end

  assign word_ready = ready_q;
  assign busy       = busy_q;
  assign data_out   = dout_q;
  assign sel        = sel_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dmux_seq_driver.sv
// Bench for dmux_seq_driver: two configurations share one stimulus stream
// and are compared each cycle against a frame-position model.
module tb_dmux_seq_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] word_in = 8'd0;
  logic       word_valid = 1'b0;
  logic       abort = 1'b0;

  logic       rdy  [2];
  logic       dout [2];
  logic [2:0] sel  [2];
  logic       busy [2];
  logic       done [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmux_seq_driver #(.DWELL(1), .DESCEND(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .word_in(word_in),
    .word_valid(word_valid), .word_ready(rdy[0]), .abort(abort),
    .data_out(dout[0]), .sel(sel[0]), .busy(busy[0]),
    .frame_done(done[0])
  );

  dmux_seq_driver #(.DWELL(3), .DESCEND(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .word_in(word_in),
    .word_valid(word_valid), .word_ready(rdy[1]), .abort(abort),
    .data_out(dout[1]), .sel(sel[1]), .busy(busy[1]),
    .frame_done(done[1])
  );

  function automatic int dw(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit ds(int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  // model: m_p counts cycles since the first channel became visible
  bit       m_busy [2];
  int       m_p    [2];
  bit [7:0] m_w    [2];
  bit       m_done [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 1'b0;
        m_p[k]    = 0;
        m_w[k]    = 8'd0;
        m_done[k] = 1'b0;
      end else if (m_busy[k]) begin
        m_done[k] = 1'b0;
        if (abort) begin
          m_busy[k] = 1'b0;
        end else begin
          m_p[k] = m_p[k] + 1;
          if (m_p[k] == 8 * dw(k)) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
          end
        end
      end else begin
        m_done[k] = 1'b0;
        if (word_valid && !abort) begin
          m_busy[k] = 1'b1;
          m_p[k]    = 0;
          m_w[k]    = word_in;
        end
      end
    end
  end

  function automatic int exp_sel(int k);
    int ch;
    if (!m_busy[k]) return 0;
    ch = m_p[k] / dw(k);
    return ds(k) ? 7 - ch : ch;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        bit [7:0] w;
        int s;
        w = m_w[k];
        s = exp_sel(k);
        chk($sformatf("m%0d_ready", k), int'(rdy[k]), int'(!m_busy[k]));
        chk($sformatf("m%0d_busy", k), int'(busy[k]), int'(m_busy[k]));
        chk($sformatf("m%0d_sel", k), int'(sel[k]), s);
        chk($sformatf("m%0d_data", k), int'(dout[k]),
            m_busy[k] ? int'(w[s]) : 0);
        chk($sformatf("m%0d_done", k), int'(done[k]), int'(m_done[k]));
      end
    end
  end

  // one-cycle valid; returns at the negedge where the first channel shows
  task automatic send(logic [7:0] w);
    word_in    = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] seq;
    int nb, nd, fs;

    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(rdy[0]), 1);
    chk("rst_sel", int'(sel[1]), 0);
    chk("rst_busy", int'(busy[0]), 0);

    // ascending DWELL=1 scan of A5
    send(8'hA5);
    for (int c = 0; c < 8; c++) begin
      seq[c] = dout[0];
      chk("asc_sel", int'(sel[0]), c);
      @(negedge clk);
    end
    chk("asc_data", int'(seq), 32'hA5);
    chk("asc_done", int'(done[0]), 1);
    chk("asc_ready", int'(rdy[0]), 1);
    idle(20);

    // descending DWELL=3 scan of 81
    nb = 0; nd = 0;
    send(8'h81);
    fs = int'(sel[1]);
    for (int c = 0; c < 30; c++) begin
      if (busy[1]) nb++;
      if (dout[1]) nd++;
      @(negedge clk);
    end
    chk("desc_first_sel", fs, 7);
    chk("desc_busy_cycles", nb, 24);
    chk("desc_data_cycles", nd, 6);

    // reset during channel 3
    send(8'hA5);
    idle(3);
    chk("midrst_sel_pre", int'(sel[0]), 3);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_sel", int'(sel[k]), 0);
      chk("midrst_data", int'(dout[k]), 0);
      chk("midrst_busy", int'(busy[k]), 0);
      chk("midrst_ready", int'(rdy[k]), 1);
      chk("midrst_done", int'(done[k]), 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(4);

    // back-to-back: valid held, FF then 00
    word_in    = 8'hFF;
    word_valid = 1'b1;
    idle(8);
    word_in = 8'h00;
    @(negedge clk);
    chk("b2b_done", int'(done[0]), 1);
    chk("b2b_gap_data", int'(dout[0]), 0);
    chk("b2b_gap_sel", int'(sel[0]), 0);
    @(negedge clk);
    chk("b2b_second_busy", int'(busy[0]), 1);
    chk("b2b_second_data", int'(dout[0]), 0);
    idle(40);
    word_valid = 1'b0;
    idle(40);

    // abort at channel 4
    send(8'hFF);
    idle(4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    chk("abort_data", int'(dout[0]), 0);
    @(negedge clk);
    chk("abort_done2", int'(done[0]), 0);

    // abort on the last-channel edge
    send(8'hF0);
    chk("post_abort_busy", int'(busy[0]), 1);
    idle(7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_last_done", int'(done[0]), 0);
    chk("abort_last_ready", int'(rdy[0]), 1);

    // abort in IDLE blocks the transfer
    word_in    = 8'h5A;
    word_valid = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", int'(busy[0]), 0);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_take", int'(busy[0]), 1);
    word_valid = 1'b0;
    idle(30);

    // word_in changes mid-frame are ignored
    send(8'h3C);
    word_in = 8'h00;
    for (int c = 0; c < 8; c++) begin
      seq[c] = dout[0];
      @(negedge clk);
    end
    chk("stable_data", int'(seq), 32'h3C);
    idle(30);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      word_in    = 8'($urandom);
      word_valid = ($urandom_range(0, 9) < 7);
      abort      = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    word_valid = 1'b0;
    abort      = 1'b0;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
